picorv32_tohost_monitor: RTL and testbench

Passive end-of-test monitor that snoops the CPU data-memory port between picorv32_mem_top and the data SRAM. It collects register-dump words the program writes to a dump address into a FIFO and streams them out over valid/ready. It detects the stop write, drains the FIFO, and then raises a sticky stop. A watchdog ends runs that never stop.

---
 rtl/picorv32_tohost_pkg.sv | 14 +
 rtl/tohost_sync_fifo.sv | 54 +++++
 rtl/picorv32_tohost_monitor.sv | 107 ++++++++++
 tb/tb_picorv32_tohost_monitor.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/picorv32_tohost_pkg.sv
// rtl/picorv32_tohost_pkg.sv - shared types and constants for the tohost monitor
package picorv32_tohost_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        DRAIN   = 2'd1,
        DONE    = 2'd2,
        TIMEOUT = 2'd3
    } state_e;

    localparam logic [31:0] TimeoutExitCode = 32'hFFFF_FFFF;
    localparam logic [3:0]  FullStrb        = 4'hF;

endpackage

// File: rtl/tohost_sync_fifo.sv
// rtl/tohost_sync_fifo.sv - synchronous FIFO with registered storage and push-through-full on pop
module tohost_sync_fifo #(
    parameter int unsigned Width = 32,
    parameter int unsigned Depth = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [Width-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [Width-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(Depth):0]   count_o
);
    localparam int unsigned PtrW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]    count_q;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (PtrW+1)'(Depth));
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A pop frees a slot in the same cycle, so a push into a full FIFO is accepted then.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/picorv32_tohost_monitor.sv
// rtl/picorv32_tohost_monitor.sv - snoops data-port writes for register dumps, stop and watchdog
module picorv32_tohost_monitor
    import picorv32_tohost_pkg::*;
#(
    parameter logic [31:0] StopAddr      = 32'h0000_0000,
    parameter logic [31:0] DumpAddr      = 32'h0000_0010,
    parameter int unsigned FifoDepth     = 16,
    parameter int unsigned TimeoutCycles = 1 << 20
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        mem_req_i,
    input  logic        mem_gnt_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [3:0]  mem_strb_i,
    output logic        dump_valid_o,
    input  logic        dump_ready_i,
    output logic [31:0] dump_data_o,
    output logic        dump_overflow_o,
    output logic        stop_o,
    output logic        timeout_o,
    output logic [31:0] exit_code_o
);
    localparam int unsigned CntW = $clog2(FifoDepth) + 1;
    localparam int unsigned WdW  = $clog2(TimeoutCycles) + 1;

    state_e          state_q, state_d;
    logic [31:0]     exit_q, exit_d;
    logic [WdW-1:0]  wd_q, wd_d;
    logic            ovf_q, ovf_d;

    logic            fire, dump_fire, stop_fire;
    logic            push, pop, full, empty;
    logic [CntW-1:0] count;
    logic [31:0]     head;

    assign fire      = mem_req_i & mem_gnt_i & mem_we_i & (mem_strb_i == FullStrb);
    assign dump_fire = fire & (mem_addr_i == DumpAddr);
    assign stop_fire = fire & (mem_addr_i == StopAddr);

    assign push = (state_q == RUN) & dump_fire;
    assign pop  = ~empty & dump_ready_i;

    tohost_sync_fifo #(
        .Width (32),
        .Depth (FifoDepth)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .wdata_i (mem_wdata_i),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    always_comb begin
        state_d = state_q;
        exit_d  = exit_q;
        wd_d    = wd_q;
        ovf_d   = ovf_q | (push & full & ~pop);
        unique case (state_q)
            RUN: begin
                wd_d = wd_q + 1'b1;
                // A stop landing on the expiry cycle still counts as a normal finish.
                if (stop_fire) begin
                    state_d = DRAIN;
                    exit_d  = mem_wdata_i;
                end else if (wd_q == WdW'(TimeoutCycles - 1)) begin
                    state_d = TIMEOUT;
                    exit_d  = TimeoutExitCode;
                end
            end
            DRAIN: begin
                if (count == '0) state_d = DONE;
            end
            DONE:    ;
            TIMEOUT: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= RUN;
            exit_q  <= '0;
            wd_q    <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            exit_q  <= exit_d;
            wd_q    <= wd_d;
            ovf_q   <= ovf_d;
        end
    end

    assign dump_valid_o    = ~empty;
    assign dump_data_o     = empty ? 32'h0 : head;
    assign dump_overflow_o = ovf_q;
    assign stop_o          = (state_q == DONE);
    assign timeout_o       = (state_q == TIMEOUT);
    assign exit_code_o     = exit_q;

endmodule

// File: tb/tb_picorv32_tohost_monitor.sv
// tb/tb_picorv32_tohost_monitor.sv - directed and randomized checks against a queue-based reference model
module tb_picorv32_tohost_monitor;

    localparam logic [31:0] STOP  = 32'h0000_0000;
    localparam logic [31:0] DUMP  = 32'h0000_0010;
    localparam int          DEPTH = 16;
    localparam int          TO    = 100;

    localparam int M_RUN = 0, M_DRAIN = 1, M_DONE = 2, M_TIMEOUT = 3;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        mem_req_i, mem_gnt_i, mem_we_i;
    logic [31:0] mem_addr_i, mem_wdata_i;
    logic [3:0]  mem_strb_i;
    logic        dump_valid_o, dump_ready_i;
    logic [31:0] dump_data_o;
    logic        dump_overflow_o, stop_o, timeout_o;
    logic [31:0] exit_code_o;

    int checks = 0;
    int failures = 0;

    logic [31:0] mq[$];
    int          mst;
    int          runs;
    bit          movf;
    logic [31:0] mexit;
    bit          just_reset;

    picorv32_tohost_monitor #(
        .StopAddr      (STOP),
        .DumpAddr      (DUMP),
        .FifoDepth     (DEPTH),
        .TimeoutCycles (TO)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .mem_req_i       (mem_req_i),
        .mem_gnt_i       (mem_gnt_i),
        .mem_we_i        (mem_we_i),
        .mem_addr_i      (mem_addr_i),
        .mem_wdata_i     (mem_wdata_i),
        .mem_strb_i      (mem_strb_i),
        .dump_valid_o    (dump_valid_o),
        .dump_ready_i    (dump_ready_i),
        .dump_data_o     (dump_data_o),
        .dump_overflow_o (dump_overflow_o),
        .stop_o          (stop_o),
        .timeout_o       (timeout_o),
        .exit_code_o     (exit_code_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference: the FIFO is a queue, the test phase a small integer, the watchdog a count of RUN cycles.
    task automatic model_step(input bit rst_n, input bit req, input bit gnt, input bit we,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] strb, input bit ready);
        bit fire;
        bit was_empty;
        if (!rst_n) begin
            mq.delete();
            mst = M_RUN;
            runs = 0;
            movf = 0;
            mexit = 32'h0;
            just_reset = 1;
            return;
        end
        just_reset = 0;
        fire = req && gnt && we && (strb == 4'hF);
        was_empty = (mq.size() == 0);
        if (!was_empty && ready) void'(mq.pop_front());
        case (mst)
            M_RUN: begin
                if (fire && addr == DUMP) begin
                    if (mq.size() < DEPTH) mq.push_back(wdata);
                    else movf = 1;
                end
                runs++;
                if (fire && addr == STOP) begin
                    mexit = wdata;
                    mst = M_DRAIN;
                end else if (runs == TO) begin
                    mexit = 32'hFFFF_FFFF;
                    mst = M_TIMEOUT;
                end
            end
            M_DRAIN: if (was_empty) mst = M_DONE;
            default: ;
        endcase
    endtask

    task automatic check_outputs();
        check_eq("valid", dump_valid_o, (mq.size() > 0) ? 32'd1 : 32'd0);
        if (mq.size() > 0) check_eq("data", dump_data_o, mq[0]);
        else if (just_reset) check_eq("data_rst", dump_data_o, 32'h0);
        check_eq("overflow", dump_overflow_o, movf);
        check_eq("stop", stop_o, (mst == M_DONE) ? 32'd1 : 32'd0);
        check_eq("timeout", timeout_o, (mst == M_TIMEOUT) ? 32'd1 : 32'd0);
        check_eq("exit_code", exit_code_o, mexit);
    endtask

    // Called at a falling edge: drive inputs, advance model, clock once, check at next falling edge.
    task automatic cycle(input bit rst_n, input bit req, input bit gnt, input bit we,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input bit ready);
        rst_ni       = rst_n;
        mem_req_i    = req;
        mem_gnt_i    = gnt;
        mem_we_i     = we;
        mem_addr_i   = addr;
        mem_wdata_i  = wdata;
        mem_strb_i   = strb;
        dump_ready_i = ready;
        model_step(rst_n, req, gnt, we, addr, wdata, strb, ready);
        @(posedge clk_i);
        @(negedge clk_i);
        check_outputs();
    endtask

    task automatic do_reset();
        cycle(0, 0, 0, 0, 32'h0, 32'h0, 4'h0, 0);
    endtask

    task automatic idle(input int n, input bit ready);
        for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 32'h0, 32'h0, 4'h0, ready);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] wdata, input bit ready);
        cycle(1, 1, 1, 1, addr, wdata, 4'hF, ready);
    endtask

    initial begin
        int ready_pct;
        int stop_pct;
        int sel;
        logic [31:0] a;
        rst_ni = 1'b0;
        mem_req_i = 0; mem_gnt_i = 0; mem_we_i = 0;
        mem_addr_i = 0; mem_wdata_i = 0; mem_strb_i = 0; dump_ready_i = 0;
        mq.delete(); mst = M_RUN; runs = 0; movf = 0; mexit = 0; just_reset = 1;
        @(negedge clk_i);

        // Happy path
        do_reset();
        wr(DUMP, 32'hA, 1);
        wr(DUMP, 32'hB, 1);
        wr(DUMP, 32'hC, 1);
        wr(STOP, 32'h5, 1);
        idle(4, 1);

        // Backpressure with 17 dumps, then drain
        do_reset();
        for (int i = 0; i < 17; i++) wr(DUMP, 32'h100 + i, 0);
        idle(20, 1);

        // Full plus simultaneous push/pop
        do_reset();
        for (int i = 0; i < 16; i++) wr(DUMP, 32'h200 + i, 0);
        wr(DUMP, 32'h2FF, 1);
        idle(2, 0);
        idle(18, 1);

        // Ignored writes
        do_reset();
        cycle(1, 1, 1, 1, DUMP, 32'hDEAD, 4'h3, 1);
        cycle(1, 1, 1, 0, STOP, 32'hBEEF, 4'hF, 1);
        cycle(1, 1, 0, 1, STOP, 32'hCAFE, 4'hF, 1);
        cycle(1, 1, 0, 1, DUMP, 32'hCAFE, 4'hF, 1);
        idle(3, 1);

        // Watchdog, then a late stop that must be ignored
        do_reset();
        wr(DUMP, 32'h77, 0);
        idle(104, 0);
        wr(STOP, 32'h9, 1);
        idle(3, 1);

        // Reset while draining
        do_reset();
        for (int i = 0; i < 4; i++) wr(DUMP, 32'h300 + i, 0);
        wr(STOP, 32'h3, 0);
        idle(2, 0);
        do_reset();
        idle(3, 1);

        // Stop on the expiry cycle
        do_reset();
        idle(TO - 1, 1);
        wr(STOP, 32'h42, 1);
        idle(3, 1);

        // Randomized episodes
        for (int ep = 0; ep < 24; ep++) begin
            ready_pct = $urandom_range(0, 100);
            stop_pct  = (ep % 3 == 0) ? 0 : $urandom_range(1, 3);
            do_reset();
            for (int c = 0; c < 220; c++) begin
                sel = $urandom_range(0, 99);
                if (sel < 55) a = DUMP;
                else if (sel < 55 + stop_pct) a = STOP;
                else if (sel < 80) a = 32'h0000_0014;
                else a = $urandom | 32'h1;
                cycle(($urandom_range(0, 299) != 0),
                      ($urandom_range(0, 9) != 0),
                      ($urandom_range(0, 9) != 0),
                      ($urandom_range(0, 5) != 0),
                      a, $urandom,
                      ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'hF,
                      ($urandom_range(0, 99) < ready_pct));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
